// File: rtl/hawkes_pkg.sv
// hawkes_pkg: shared types, Q-format widths and LFSR constants for the Hawkes Monte-Carlo blocks
package hawkes_pkg;
  localparam int LAMBDA_W = 9;
  localparam int S_W = 9;
  localparam int TIME_W = 16;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
  localparam logic [1:0] K_EXCITE = 2'b11;
  localparam logic [1:0] K_DECAY = 2'b10;
  typedef enum logic [2:0] {IDLE, ISSUE, GUARD, WAIT, DECIDE, FINISH, ERROR} state_t;
  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ LFSR_MASK) : (x >> 1);
  endfunction
endpackage

// File: rtl/hawkes_event_gen_if.sv
// hawkes_event_gen_if: request/response handshake between the event sampler and the state calculator
interface hawkes_event_gen_if;
  import hawkes_pkg::*;
  logic calc_start;
  logic [S_W-1:0] calc_s;
  logic [1:0] calc_k;
  logic calc_done;
  logic [LAMBDA_W-1:0] calc_lambda;
  modport master(output calc_start, calc_s, calc_k, input calc_done, calc_lambda);
  modport slave(input calc_start, calc_s, calc_k, output calc_done, calc_lambda);
endinterface

// File: rtl/hawkes_event_gen_lfsr16.sv
// lfsr16: 16-bit Galois LFSR, seed loaded on reset, advances when en is high
module lfsr16
  import hawkes_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] q
);
  // an all-zero seed would lock the register, so fall back to the default
  localparam logic [15:0] INIT = (SEED == 16'h0000) ? LFSR_DEFAULT : SEED;
  always_ff @(posedge clk) begin
    if (!rst_n) q <= INIT;
    else if (en) q <= lfsr_next(q);
  end
endmodule

// File: rtl/hawkes_event_gen.sv
// hawkes_event_gen: steps simulated time, requests lambda from the state calculator and thins events with an LFSR
module hawkes_event_gen
  import hawkes_pkg::*;
#(
  parameter logic [7:0]  STEP       = 8'd16,
  parameter int          MAX_EVENTS = 16,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          TIMEOUT    = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  hawkes_event_gen_if.master  calc,
  output logic                event_valid,
  output logic [TIME_W-1:0]   event_time,
  output logic [TIME_W-1:0]   event_count,
  output logic                busy,
  output logic                finished,
  output logic                timeout_err
);
  state_t state, state_nx;
  logic [TIME_W-1:0] time_acc;
  logic [15:0] wait_cnt, lfsr;
  logic [LAMBDA_W-1:0] lambda_q, pq, u;
  logic pend_exc, accept, last, active;
  lfsr16 #(.SEED(SEED)) u_lfsr (.clk(clk), .rst_n(rst_n), .en(state == DECIDE), .q(lfsr));
  // acceptance probability lambda*STEP in Q1.8; the low byte of the LFSR is the uniform draw
  assign pq = LAMBDA_W'((17'(lambda_q) * 17'(STEP)) >> 8);
  assign u = LAMBDA_W'(lfsr & 16'h00FF);
  assign accept = u < pq;
  assign last = event_count == TIME_W'(MAX_EVENTS - 1);
  assign active = state inside {ISSUE, GUARD, WAIT};
  assign calc.calc_start = state == ISSUE;
  assign calc.calc_s = active ? S_W'(STEP) : '0;
  assign calc.calc_k = active ? (pend_exc ? K_EXCITE : K_DECAY) : 2'b00;
  assign busy = !(state inside {IDLE, FINISH});
  assign finished = state == FINISH;
  assign timeout_err = state == ERROR;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = run ? ISSUE : IDLE;
      ISSUE:   state_nx = GUARD;
      GUARD:   state_nx = WAIT;
      WAIT:    state_nx = calc.calc_done ? DECIDE : (wait_cnt == 16'(TIMEOUT - 1)) ? ERROR : WAIT;
      DECIDE:  state_nx = (accept && last) ? FINISH : run ? ISSUE : IDLE;
      FINISH:  state_nx = run ? FINISH : IDLE;
      default: state_nx = state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      time_acc    <= '0;
      wait_cnt    <= '0;
      lambda_q    <= '0;
      pend_exc    <= 1'b0;
      event_valid <= 1'b0;
      event_time  <= '0;
      event_count <= '0;
    end else begin
      state       <= state_nx;
      event_valid <= state == DECIDE && accept;
      wait_cnt    <= state == WAIT ? wait_cnt + 16'd1 : '0;
      if (state == ISSUE) time_acc <= time_acc + TIME_W'(STEP);
      if (state == WAIT && calc.calc_done) lambda_q <= calc.calc_lambda;
      if (state == DECIDE) pend_exc <= accept;
      if (state == DECIDE && accept) begin
        event_time  <= time_acc;
        event_count <= event_count + 1'b1;
      end
      if (state == FINISH && !run) begin
        event_count <= '0;
        time_acc    <= '0;
      end
    end
  end
endmodule

// File: tb/tb_hawkes_event_gen.sv
// tb_hawkes_event_gen: randomized steps against a step-level thinning model, plus timeout and run-to-finish cases
module tb_hawkes_event_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run_a = 1'b0;
  logic run_b = 1'b0;
  always #5 clk = ~clk;
  hawkes_event_gen_if ia();
  hawkes_event_gen_if ib();
  logic ev_a, busy_a, fin_a, to_a, ev_b, busy_b, fin_b, to_b;
  logic [15:0] et_a, ec_a, et_b, ec_b;
  hawkes_event_gen #(.STEP(8'd16), .MAX_EVENTS(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .run(run_a), .calc(ia),
    .event_valid(ev_a), .event_time(et_a), .event_count(ec_a),
    .busy(busy_a), .finished(fin_a), .timeout_err(to_a));
  hawkes_event_gen #(.STEP(8'hFF), .MAX_EVENTS(4), .SEED(16'h1234)) dut_b (
    .clk(clk), .rst_n(rst_n), .run(run_b), .calc(ib),
    .event_valid(ev_b), .event_time(et_b), .event_count(ec_b),
    .busy(busy_b), .finished(fin_b), .timeout_err(to_b));
  int checks = 0;
  int errors = 0;
  logic [15:0] ml, mt;
  int mc;
  bit mp;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [15:0] lnext(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction
  // one full request on DUT A: wait for start, answer after dly WAIT-side cycles, then check the outcome
  task automatic step_a(input logic [8:0] lam, input int dly, input bit held, input bit drop);
    int n = 0;
    int cnt;
    bit acc;
    while (!ia.calc_start && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("start", 32'(ia.calc_start), 1);
    chk("calc_k", 32'(ia.calc_k), mp ? 3 : 2);
    chk("calc_s", 32'(ia.calc_s), 16);
    ia.calc_lambda = lam;
    repeat (1 + dly) @(negedge clk);
    ia.calc_done = 1'b1;
    if (drop) run_a = 1'b0;
    @(negedge clk);
    chk("decide_start_busy", 32'({ia.calc_start, busy_a}), 1);
    if (!held) ia.calc_done = 1'b0;
    mt = mt + 16'd16;
    acc = int'(ml[7:0]) < (int'(lam) * 16) / 256;
    ml = lnext(ml);
    mp = acc;
    if (acc) mc++;
    @(negedge clk);
    chk("event_valid", 32'(ev_a), 32'(acc));
    if (acc) chk("event_time", 32'(et_a), 32'(mt));
    chk("event_count", 32'(ec_a), 32'(mc));
    chk("finished", 32'(fin_a), 32'(mc == 3));
    if (mc == 3) begin
      chk("finish_busy", 32'(busy_a), 0);
      run_a = 1'b0;
      @(negedge clk);
      chk("finish_clear", 32'({fin_a, ec_a}), 0);
      mc = 0;
      mt = 16'd0;
      if (!drop) run_a = 1'b1;
    end else if (drop) begin
      chk("drop_busy", 32'(busy_a), 0);
      cnt = 0;
      repeat (8) begin
        @(negedge clk);
        cnt += int'(ia.calc_start);
      end
      chk("drop_no_start", 32'(cnt), 0);
    end else chk("next_issue", 32'(ia.calc_start), 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int n, first, cnt;
    ia.calc_done = 1'b0;
    ia.calc_lambda = '0;
    ib.calc_done = 1'b0;
    ib.calc_lambda = '0;
    run_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_a_ctl", 32'({ia.calc_start, ia.calc_s, ia.calc_k, ev_a, busy_a, fin_a, to_a}), 0);
    chk("rst_a_data", {et_a, ec_a}, 0);
    chk("rst_b_ctl", 32'({ib.calc_start, ib.calc_s, ib.calc_k, ev_b, busy_b, fin_b, to_b}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_start", 32'({ia.calc_start, ia.calc_s, ia.calc_k}), 32'({1'b1, 9'd16, 2'b10}));
    ml = 16'hACE1;
    mt = 16'd0;
    mc = 0;
    mp = 1'b0;
    for (int i = 0; i < 200; i++) step_a(9'd0, int'($urandom_range(1, 3)), 1'b0, 1'b0);
    for (int i = 0; i < 300 && mc == 0; i++) step_a(9'h1FF, 1, 1'b0, 1'b0);
    chk("first_hit", 32'(mc), 1);
    for (int i = 0; i < 100; i++) step_a(9'h1FF, int'($urandom_range(1, 4)), 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) step_a(9'($urandom_range(0, 511)), int'($urandom_range(1, 4)), 1'b0, 1'b0);
    ia.calc_done = 1'b1;
    for (int i = 0; i < 20; i++) step_a(9'h1FF, 1, 1'b1, 1'b0);
    step_a(9'h1FF, 1, 1'b1, 1'b1);
    ia.calc_done = 1'b0;
    run_a = 1'b1;
    n = 0;
    while (!ia.calc_start && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("to_start", 32'(ia.calc_start), 1);
    first = 0;
    cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (to_a && first == 0) first = i;
      cnt += int'(ia.calc_start);
    end
    chk("timeout_cycle", 32'(first), 66);
    chk("error_no_start", 32'(cnt), 0);
    chk("error_hold", 32'({to_a, busy_a}), 3);
    rst_n = 1'b0;
    run_a = 1'b0;
    @(negedge clk);
    chk("rst_mid_ctl", 32'({ia.calc_start, ia.calc_s, ia.calc_k, ev_a, busy_a, fin_a, to_a}), 0);
    chk("rst_mid_data", {et_a, ec_a}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ib.calc_done = 1'b1;
    ib.calc_lambda = 9'h1FF;
    run_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!ib.calc_start && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("b_start", 32'(ib.calc_start), 1);
      chk("b_calc_k", 32'(ib.calc_k), i == 0 ? 2 : 3);
      chk("b_calc_s", 32'(ib.calc_s), 255);
      repeat (4) @(negedge clk);
      chk("b_event_valid", 32'(ev_b), 1);
      chk("b_event_time", 32'(et_b), 32'((255 * (i + 1)) % 65536));
      chk("b_event_count", 32'(ec_b), 32'(i + 1));
    end
    chk("b_finished_idle", 32'({fin_b, busy_b}), 2);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      cnt += int'(ib.calc_start);
    end
    chk("b_no_start", 32'(cnt), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
